button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 137 +++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronised, debounced push-button with press/long-press/held/repeat/release indications.
// Optional feature macro BTN_AUTOREPEAT_EN enables the auto-repeat pulse on rpt.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 2000000,
  parameter int REPEAT_CYCLES   = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic long_press,
  output logic held,
  output logic rpt,
  output logic rel
);
  localparam int MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                        ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES) :
                        ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int W = $clog2(MAXC);
  localparam logic [W-1:0] DEB_MAX  = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] HOLD_MAX = W'(HOLD_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, PRESSED, HELD, DEB_REL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic s1_q, s_q, flag_q, flag_d;
  logic out_q, out_d, long_q, long_d, held_q, held_d, rel_q, rel_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      out_q   <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= in;
      s_q     <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      out_q   <= out_d;
      long_q  <= long_d;
      held_q  <= held_d;
      rel_q   <= rel_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    flag_d  = flag_q;
    out_d   = 1'b0;
    long_d  = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = s_q ? DEB_PRESS : IDLE;
      end
      DEB_PRESS: begin
        if (!s_q) state_d = IDLE;
        else if (cnt_q == DEB_MAX) begin
          state_d = PRESSED;
          out_d   = 1'b1;
        end
      end
      PRESSED: begin
        if (!s_q) begin
          state_d = DEB_REL;
          flag_d  = 1'b0;
        end else if (cnt_q == HOLD_MAX) begin
          state_d = HELD;
          long_d  = 1'b1;
        end
      end
      HELD: begin
        if (!s_q) begin
          state_d = DEB_REL;
          flag_d  = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (cnt_q == W'(REPEAT_CYCLES - 1)) cnt_d = '0;
`else
        else cnt_d = '0;
`endif
      end
      DEB_REL: begin
        if (s_q) state_d = flag_q ? HELD : PRESSED;
        else if (cnt_q == DEB_MAX) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    held_d = (state_d == HELD) || (state_d == DEB_REL && flag_d);
  end
`ifdef BTN_AUTOREPEAT_EN
  logic rpt_q, rpt_d;
  // Repeat fires on HELD entry and on every counter wrap while staying in HELD.
  assign rpt_d = (state_q == PRESSED && state_d == HELD) ||
                 (state_q == HELD && state_d == HELD && cnt_q == W'(REPEAT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= 1'b0;
    else rpt_q <= rpt_d;
  end
  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif
  assign out        = out_q;
  assign long_press = long_q;
  assign held       = held_q;
  assign rel        = rel_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random press/bounce traffic against a run-length reference model.
module tb_button_conditioner;
  localparam int D = 4, H = 10, R = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in = 1'b0;
  logic out, long_press, held, rpt, rel;
  int checks = 0, failures = 0;
  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .long_press(long_press),
    .held(held), .rpt(rpt), .rel(rel)
  );
  always #5 clk = ~clk;
  // Model: synchroniser pipe, run length of the synchronised level, and a coarse press level
  // (0 released, 1 pressed, 2 held) with an anchor edge from which hold/repeat times are measured.
  logic m_s1, m_s, run_v;
  int run_len, lvl, anchor, k, k0;
  int e_out, e_long, e_held, e_rpt, e_rel;
  int t_out, t_long, t_rel, n_out, n_long, n_rpt, n_rel;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, k, got, exp);
    end
  endtask
  task automatic model_reset();
    m_s1 = 0; m_s = 0; run_v = 0; run_len = 0; lvl = 0; anchor = 0;
    e_out = 0; e_long = 0; e_held = 0; e_rpt = 0; e_rel = 0;
  endtask
  task automatic model_edge();
    logic s_use;
    s_use = m_s;
    m_s = m_s1;
    m_s1 = in;
    if (s_use == run_v) run_len++;
    else begin
      run_v = s_use;
      run_len = 1;
    end
    e_out = 0; e_long = 0; e_rpt = 0; e_rel = 0;
    if (lvl == 0) begin
      if (s_use && run_len == D + 1) begin
        lvl = 1; anchor = k; e_out = 1;
      end
    end else if (!s_use) begin
      if (run_len == D + 1) begin
        lvl = 0; e_rel = 1;
      end
    end else if (run_len == 1) anchor = k;
    else if (lvl == 1 && k - anchor == H) begin
      lvl = 2; anchor = k; e_long = 1; e_rpt = AR;
    end else if (lvl == 2 && AR && (k - anchor) % R == 0) e_rpt = 1;
    e_held = (lvl == 2);
    k++;
  endtask
  task automatic mark();
    k0 = k; t_out = -1; t_long = -1; t_rel = -1;
    n_out = 0; n_long = 0; n_rpt = 0; n_rel = 0;
  endtask
  task automatic step(input logic v);
    int idx;
    in = v;
    @(posedge clk);
    idx = k - k0;
    model_edge();
    #1;
    chk("out", out, e_out);
    chk("long_press", long_press, e_long);
    chk("held", held, e_held);
    chk("rpt", rpt, e_rpt);
    chk("rel", rel, e_rel);
    if (out && t_out < 0) t_out = idx;
    if (long_press && t_long < 0) t_long = idx;
    if (rel && t_rel < 0) t_rel = idx;
    n_out += int'(out); n_long += int'(long_press); n_rpt += int'(rpt); n_rel += int'(rel);
  endtask
  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out", out, 0);
    chk("rst_long", long_press, 0);
    chk("rst_held", held, 0);
    chk("rst_rpt", rpt, 0);
    chk("rst_rel", rel, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    k = 0;
    model_reset();
    mark();
    #3;
    chk("init_out", out, 0);
    chk("init_held", held, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 5);
    mark(); run(1, 3); run(0, 12);
    chk("glitch_n_out", n_out, 0);
    chk("glitch_n_rel", n_rel, 0);
    mark(); run(1, 12); run(0, 12);
    chk("short_out_edge", t_out, 6);
    chk("short_n_long", n_long, 0);
    chk("short_rel_edge", t_rel, 18);
    chk("short_n_rel", n_rel, 1);
    mark(); run(1, 40);
    chk("hold_out_edge", t_out, 6);
    chk("hold_long_edge", t_long, 16);
    chk("hold_n_rpt", n_rpt, AR ? 8 : 0);
    mark(); run(0, 2); run(1, 10);
    chk("bounce_n_rel", n_rel, 0);
    chk("bounce_held", held, 1);
    mark(); run(0, 12);
    chk("hold_rel_edge", t_rel, 6);
    mark(); run(1, 25);
    chk("pre_rst_held", held, 1);
    do_reset();
    mark(); run(1, 12);
    chk("post_rst_out_edge", t_out, 6);
    run(0, 10);
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) run(1'($urandom), $urandom_range(1, 6));
      else run(1'($urandom), $urandom_range(1, 30));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
